// File: rtl/instruction_fetch.sv
// IF stage of the 5-stage MIPS pipeline.
// Holds the PC and a word-addressed instruction memory that the debug unit
// loads, and registers the fetched word and its PC+4 into the IF/ID boundary.
// Fetch is controlled by a three-state FSM: IDLE (loadable), RUN, and HALTED.
module instruction_fetch #(
  parameter int unsigned ADDR_BITS      = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned IMEM_ADDR_BITS = 8,
  parameter logic [5:0]  HALT_OPCODE    = 6'h3F
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      stall,
  input  logic                      branch_taken,
  input  logic [ADDR_BITS-1:0]      branch_target,
  input  logic                      prog_we,
  input  logic [IMEM_ADDR_BITS-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0]     prog_data,
  output logic [DATA_WIDTH-1:0]     inst_out,
  output logic [ADDR_BITS-1:0]      next_pc_out,
  output logic [ADDR_BITS-1:0]      pc_out,
  output logic                      halt_out
);

  localparam int unsigned IMEM_DEPTH = 2 ** IMEM_ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_BITS-1:0]    pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   inst_q, inst_d;
  logic [ADDR_BITS-1:0]    npc_q, npc_d;
  logic                    halt_q, halt_d;
  logic                    mem_we;

  logic [DATA_WIDTH-1:0]   mem [IMEM_DEPTH];
  logic [DATA_WIDTH-1:0]   fetch_word;
  logic [ADDR_BITS-1:0]    pc_plus4;
  logic                    is_halt_word;

  // PC bits above the word index are ignored, so the memory aliases across
  // the full address space.
  assign fetch_word   = mem[pc_q[IMEM_ADDR_BITS+1:2]];
  assign pc_plus4     = pc_q + ADDR_BITS'(4);
  assign is_halt_word = (fetch_word[DATA_WIDTH-1 -: 6] == HALT_OPCODE);

  // Loader write port; only the FSM decides when a write is allowed.
  // NOTE: the memory array has no reset so it maps onto RAM and survives a
  // pipeline reset with the loaded program intact.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // State and IF/ID register update, with synchronous reset taking priority.
  // NOTE: non-blocking assignments here keep every register sampling the
  // pre-edge value of its neighbours, which is what the hardware does.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      inst_q  <= '0;
      npc_q   <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      npc_q   <= npc_d;
      halt_q  <= halt_d;
    end
  end

  // Next-state and next-register logic: branch beats stall beats fetch.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    npc_d   = npc_q;
    halt_d  = halt_q;
    mem_we  = 1'b0;

    unique case (state_q)
      IDLE: begin
        inst_d = '0;
        mem_we = prog_we;
        if (enable) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (!enable) begin
          // Any pending stall is dropped; behave as IDLE from here on.
          state_d = IDLE;
          inst_d  = '0;
        end else if (branch_taken) begin
          pc_d   = {branch_target[ADDR_BITS-1:2], 2'b00};
          inst_d = '0;
        end else if (!stall) begin
          inst_d = fetch_word;
          npc_d  = pc_plus4;
          if (is_halt_word) begin
            halt_d  = 1'b1;
            state_d = HALTED;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end

      HALTED: begin
        inst_d = '0;
      end

      default: begin
        state_d = IDLE;
        inst_d  = '0;
      end
    endcase
  end

  assign inst_out    = inst_q;
  assign next_pc_out = npc_q;
  assign pc_out      = pc_q;
  assign halt_out    = halt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch: a table of per-edge vectors with
// hand-computed IF/ID outputs, followed by a few hand-written sequences.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [31:0] prog_data;
  logic [31:0] inst_out;
  logic [31:0] next_pc_out;
  logic [31:0] pc_out;
  logic        halt_out;

  int checks = 0;
  int errors = 0;

  instruction_fetch #(
    .ADDR_BITS      (32),
    .DATA_WIDTH     (32),
    .IMEM_ADDR_BITS (8),
    .HALT_OPCODE    (6'h3F)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .prog_we       (prog_we),
    .prog_addr     (prog_addr),
    .prog_data     (prog_data),
    .inst_out      (inst_out),
    .next_pc_out   (next_pc_out),
    .pc_out        (pc_out),
    .halt_out      (halt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic        st;
    logic        br;
    logic [31:0] tgt;
    logic        we;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic [31:0] e_inst;
    logic [31:0] e_npc;
    logic [31:0] e_pc;
    logic        e_halt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic en, input logic st,
                              input logic br, input logic [31:0] tgt,
                              input logic we, input logic [7:0] wa,
                              input logic [31:0] wd, input logic [31:0] e_inst,
                              input logic [31:0] e_npc, input logic [31:0] e_pc,
                              input logic e_halt);
    vec_t v;
    v.rst = rst; v.en = en; v.st = st; v.br = br; v.tgt = tgt;
    v.we = we; v.wa = wa; v.wd = wd;
    v.e_inst = e_inst; v.e_npc = e_npc; v.e_pc = e_pc; v.e_halt = e_halt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic drive(input logic rst, input logic en, input logic st,
                       input logic br, input logic [31:0] tgt, input logic we,
                       input logic [7:0] wa, input logic [31:0] wd);
    reset = rst; enable = en; stall = st; branch_taken = br;
    branch_target = tgt; prog_we = we; prog_addr = wa; prog_data = wd;
  endtask

  initial begin
    int edges;
    bit seen;

    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0);

    //        rst en st br tgt            we wa     wd             inst           npc            pc             halt
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 8'd0,   32'h0,        32'h0,        32'h0,        32'h0,        0)); // reset
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 8'd0,   32'h20010005, 32'h0,        32'h0,        32'h0,        0)); // load
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 8'd1,   32'h20020003, 32'h0,        32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 8'd2,   32'h00221820, 32'h0,        32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 8'd3,   32'hFC000000, 32'h0,        32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 8'd7,   32'h11111111, 32'h0,        32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 8'd8,   32'h22222222, 32'h0,        32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 8'd255, 32'h33333333, 32'h0,        32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 8'd0,   32'h0,        32'h0,        32'h0,        32'h0,        0)); // IDLE->RUN
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 8'd0,   32'h0,        32'h20010005, 32'h4,        32'h4,        0)); // fetch
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 8'd0,   32'h0,        32'h20020003, 32'h8,        32'h8,        0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,        0, 8'd0,   32'h0,        32'h20020003, 32'h8,        32'h8,        0)); // stall
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,        0, 8'd0,   32'h0,        32'h20020003, 32'h8,        32'h8,        0)); // stall
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 8'd0,   32'h0,        32'h00221820, 32'hC,        32'hC,        0));
    vecs.push_back(mk(0, 1, 1, 1, 32'h1E,       1, 8'd3,   32'h0,        32'h0,        32'hC,        32'h1C,       0)); // branch+stall, we ignored
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 8'd0,   32'h0,        32'h11111111, 32'h20,       32'h20,       0)); // mem[7]
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 8'd0,   32'h0,        32'h22222222, 32'h24,       32'h24,       0));
    vecs.push_back(mk(0, 1, 0, 1, 32'hC,        0, 8'd0,   32'h0,        32'h0,        32'h24,       32'hC,        0));
    vecs.push_back(mk(0, 1, 0, 1, 32'h4,        0, 8'd0,   32'h0,        32'h0,        32'h24,       32'h4,        0)); // branch beats halt word
    vecs.push_back(mk(0, 1, 0, 1, 32'hC,        0, 8'd0,   32'h0,        32'h0,        32'h24,       32'hC,        0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,        0, 8'd0,   32'h0,        32'h0,        32'h24,       32'hC,        0)); // stalled halt word
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 8'd0,   32'h0,        32'hFC000000, 32'h10,       32'hC,        1)); // halt fetch
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 8'd0,   32'hDEADBEEF, 32'h0,        32'h10,       32'hC,        1)); // HALTED ignores
    vecs.push_back(mk(0, 1, 1, 1, 32'h40,       0, 8'd0,   32'h0,        32'h0,        32'h10,       32'hC,        1));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 8'd0,   32'h0,        32'h0,        32'h0,        32'h0,        0)); // reset in HALTED
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 8'd0,   32'h0,        32'h0,        32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 8'd0,   32'h0,        32'h20010005, 32'h4,        32'h4,        0)); // mem kept
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,        0, 8'd0,   32'h0,        32'h20010005, 32'h4,        32'h4,        0));
    vecs.push_back(mk(1, 1, 1, 0, 32'h0,        0, 8'd0,   32'h0,        32'h0,        32'h0,        32'h0,        0)); // reset mid-stall
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 8'd0,   32'h0,        32'h0,        32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 8'd0,   32'h0,        32'h20010005, 32'h4,        32'h4,        0));
    vecs.push_back(mk(0, 1, 0, 1, 32'hFFFFFFFF, 0, 8'd0,   32'h0,        32'h0,        32'h4,        32'hFFFFFFFC, 0)); // low bits forced
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 8'd0,   32'h0,        32'h33333333, 32'h0,        32'h0,        0)); // wrap, mem[255]
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 8'd0,   32'h0,        32'h20010005, 32'h4,        32'h4,        0));
    vecs.push_back(mk(0, 1, 0, 1, 32'h408,      0, 8'd0,   32'h0,        32'h0,        32'h4,        32'h408,      0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 8'd0,   32'h0,        32'h00221820, 32'h40C,      32'h40C,      0)); // alias to mem[2]
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 8'd0,   32'h0,        32'h0,        32'h0,        32'h0,        0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].st, vecs[i].br, vecs[i].tgt,
            vecs[i].we, vecs[i].wa, vecs[i].wd);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d inst_out", i), inst_out, vecs[i].e_inst);
      check($sformatf("v%0d next_pc_out", i), next_pc_out, vecs[i].e_npc);
      check($sformatf("v%0d pc_out", i), pc_out, vecs[i].e_pc);
      check($sformatf("v%0d halt_out", i), {31'b0, halt_out}, {31'b0, vecs[i].e_halt});
    end

    // First instruction must appear exactly two edges after enable rises.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 6) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
      if (inst_out === 32'h20010005) seen = 1'b1;
    end
    check("first_fetch_latency", 32'(edges), 32'd2);
    check("first_fetch_pc", pc_out, 32'h4);

    // Reset wins over a simultaneous branch request.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 8'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("reset_over_branch pc_out", pc_out, 32'h0);
    check("reset_over_branch inst_out", inst_out, 32'h0);

    // Fresh run after that reset still needs the IDLE->RUN edge first.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("rerun idle_edge inst_out", inst_out, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("rerun fetch inst_out", inst_out, 32'h20010005);
    check("rerun fetch next_pc_out", next_pc_out, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
